// File: rtl/clint_bus_bridge_if.sv
// Request/response bus between the LSU/uncached path and the CLINT bridge.
// master = requester side, slave = bridge side.
interface clint_bus_bridge_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req_valid_i;
  logic          req_ready_o;
  logic [AW-1:0] req_addr_i;
  logic          req_write_i;
  logic [DW-1:0] req_wdata_i;
  logic [DW/8-1:0] req_wstrb_i;
  logic          rsp_valid_o;
  logic          rsp_ready_i;
  logic [DW-1:0] rsp_rdata_o;
  logic          rsp_err_o;

  modport master (
    output req_valid_i, req_addr_i, req_write_i,
    output req_wdata_i, req_wstrb_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );

  modport slave (
    input  req_valid_i, req_addr_i, req_write_i,
    input  req_wdata_i, req_wstrb_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );
endinterface

// File: rtl/clint_bus_bridge.sv
// Bus front end for the CLINT timer block: single-beat valid/ready access,
// byte-strobe read-modify-write, registered MTIP. CLINT_MSIP_EN adds msip.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef MTIME_ADDR_LOW
`define MTIME_ADDR_LOW 32'h0200_BFF8
`endif
`ifndef MTIME_ADDR_HIGH
`define MTIME_ADDR_HIGH 32'h0200_BFFC
`endif
`ifndef MTIMECMP_ADDR_LOW
`define MTIMECMP_ADDR_LOW 32'h0200_4000
`endif
`ifndef MTIMECMP_ADDR_HIGH
`define MTIMECMP_ADDR_HIGH 32'h0200_4004
`endif

module clint_bus_bridge #(
  parameter int          AW        = 32,
  parameter int          DW        = `XLEN,
  parameter logic [31:0] MSIP_ADDR = 32'h0200_0000
) (
  input  logic                clk,
  input  logic                rst,
  clint_bus_bridge_if.slave   bus,
  output logic [AW-1:0]       mtime_addr_o,
  output logic                mtime_write_valid_o,
  output logic [DW-1:0]       mtime_wdata_o,
  input  logic [DW-1:0]       mtime_rdata_i,
  input  logic                mtime_ge_mtime_i,
  output logic                timer_irq_o,
  output logic                msip_o
);

  localparam int SW = DW / 8;

`ifdef CLINT_MSIP_EN
  localparam bit MSIP_EN = 1'b1;
`else
  localparam bit MSIP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    RESP
  } state_t;

  state_t        state;
  logic          a_write;
  logic          a_msip;
  logic [DW-1:0] a_wdata;
  logic [SW-1:0] a_wstrb;
  logic          msip;

  logic          aligned;
  logic          hit_timer;
  logic          hit_msip;
  logic          legal;
  logic [DW-1:0] rd_val;
  logic [DW-1:0] merged;

  always_comb begin
    aligned   = bus.req_addr_i[1:0] == 2'b00;
    hit_timer = aligned &&
      (bus.req_addr_i == AW'(`MTIME_ADDR_LOW)    ||
       bus.req_addr_i == AW'(`MTIME_ADDR_HIGH)   ||
       bus.req_addr_i == AW'(`MTIMECMP_ADDR_LOW) ||
       bus.req_addr_i == AW'(`MTIMECMP_ADDR_HIGH));
    hit_msip  = MSIP_EN && aligned &&
      (bus.req_addr_i == AW'(MSIP_ADDR));
    legal     = hit_timer || hit_msip;
  end

  always_comb begin
    rd_val = a_msip ? {{(DW-1){1'b0}}, msip} : mtime_rdata_i;
    merged = '0;
    for (int i = 0; i < SW; i++) begin
      merged[8*i +: 8] = a_wstrb[i] ? a_wdata[8*i +: 8]
                                    : rd_val[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= IDLE;
      bus.req_ready_o     <= 1'b1;
      bus.rsp_valid_o     <= 1'b0;
      bus.rsp_rdata_o     <= '0;
      bus.rsp_err_o       <= 1'b0;
      mtime_addr_o        <= '0;
      mtime_write_valid_o <= 1'b0;
      mtime_wdata_o       <= '0;
      timer_irq_o         <= 1'b0;
      a_write             <= 1'b0;
      a_msip              <= 1'b0;
      a_wdata             <= '0;
      a_wstrb             <= '0;
    end else begin
      timer_irq_o         <= mtime_ge_mtime_i;
      mtime_write_valid_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.req_valid_i) begin
            bus.req_ready_o <= 1'b0;
            bus.rsp_rdata_o <= '0;
            bus.rsp_err_o   <= 1'b0;
            mtime_addr_o    <= bus.req_addr_i;
            a_write         <= bus.req_write_i;
            a_wdata         <= bus.req_wdata_i;
            a_wstrb         <= bus.req_wstrb_i;
            a_msip          <= hit_msip;
            if (!legal) begin
              bus.rsp_err_o   <= 1'b1;
              bus.rsp_valid_o <= 1'b1;
              state           <= RESP;
            end else if (bus.req_write_i &&
                         bus.req_wstrb_i == '0) begin
              bus.rsp_valid_o <= 1'b1;
              state           <= RESP;
            end else if (bus.req_write_i &&
                         &bus.req_wstrb_i) begin
              mtime_wdata_o       <= bus.req_wdata_i;
              mtime_write_valid_o <= !hit_msip;
              state               <= WR;
            end else begin
              state <= RD;
            end
          end
        end
        RD: begin
          if (a_write) begin
            mtime_wdata_o       <= merged;
            mtime_write_valid_o <= !a_msip;
            state               <= WR;
          end else begin
            bus.rsp_rdata_o <= rd_val;
            bus.rsp_valid_o <= 1'b1;
            state           <= RESP;
          end
        end
        WR: begin
          bus.rsp_rdata_o <= '0;
          bus.rsp_valid_o <= 1'b1;
          state           <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready_i) begin
            bus.rsp_valid_o <= 1'b0;
            bus.req_ready_o <= 1'b1;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CLINT_MSIP_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      msip <= 1'b0;
    end else if (state == WR && a_msip && a_wstrb[0]) begin
      msip <= mtime_wdata_o[0];
    end
  end
`else
  assign msip = 1'b0;
`endif

  assign msip_o = msip;

endmodule
